full_adder_reg: RTL and testbench
=================================

Name: full_adder_reg

Overview:
- Registered, parameterizable binary adder: computes a + b + cin and presents sum and carry-out one clock after the operands are accepted.
- Built as a ripple chain of 1-bit full-adder cells. Default WIDTH=1 gives the classic single-bit full adder.
- Used as the arithmetic leaf cell for wider datapaths. Operands come from an upstream driver via a simple valid qualifier.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  sum/cout/ovf hold a fresh result this cycle.

Behaviour:
- Per-bit cell i:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i)
  - c_0 = cin; cout = c_WIDTH.
- Result is exact: {cout, sum} = a + b + cin, a (WIDTH+1)-bit value with no truncation beyond bit WIDTH. No saturation; wrap-around of sum is reported only via cout and ovf.
- ovf = c_WIDTH ^ c_{WIDTH-1}. For WIDTH=1, c_0 is cin, so ovf = cout ^ cin.
- Latency: exactly 1 clock.
  - Operands sampled at edge N with in_valid=1 appear on sum/cout/ovf after edge N.
  - out_valid=1 for that cycle.
- in_valid=0 at an edge:
  - sum, cout, ovf hold their previous values.
  - out_valid goes 0 after that edge.
- Throughput: one operation per cycle. Back-to-back in_valid=1 gives back-to-back results with no bubbles.
- No backpressure: the output is not held pending a consumer. The downstream must capture it in the out_valid cycle.
- Reset (rst=1 at a rising edge): sum=0, cout=0, ovf=0, out_valid=0 after that edge.
  - Reset has priority over in_valid in the same cycle; the concurrent operation is discarded.
  - Reset mid-stream: any result that would have appeared the next cycle is lost. The first valid after rst deasserts behaves normally.
- Before the first reset, output values are undefined. The bench must reset first.
- X on a, b or cin while in_valid=0 must not disturb outputs.
- The combinational carry chain must settle within one clock. No internal pipelining for any WIDTH.

Test Plan:
- Exhaustive 1-bit check (WIDTH=1), one vector per cycle over (a,b,cin) = 000..111. Required sum/cout on the next cycle:
  - 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1
  - out_valid=1 each cycle
- Reset (WIDTH=1):
  - a=1, b=1, cin=1 with in_valid=1 and rst=1 in the same cycle -> sum=0, cout=0, out_valid=0 next cycle.
  - Same vector with rst=0 one cycle later -> sum=1, cout=1.
- Hold (WIDTH=1):
  - Apply a=1, b=0, cin=0 valid, then in_valid=0 for 3 cycles with a/b/cin toggling.
  - Required: sum=1, cout=0 held; out_valid=1 then 0, 0, 0.
- Full carry ripple (WIDTH=8):
  - a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- Random back-to-back (WIDTH=8), 1000 consecutive valid vectors:
  - each result equals the reference a+b+cin one cycle later;
  - out_valid stays continuously 1.
- Reset mid-stream: assert rst for one cycle during a valid burst -> the in-flight result is dropped, outputs are 0, and the next vector after release is correct.

Source files
------------

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, with signed overflow,
// presented one clock after the operands are accepted.

module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module full_adder_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             out_valid_q;

   assign carry[0] = cin;

   // Purely combinational chain; it must settle within one clock for every WIDTH.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a_i (a[i]),
         .b_i (b[i]),
         .c_i (carry[i]),
         .s_o (sum_d[i]),
         .c_o (carry[i+1])
      );
   end

   assign cout_d = carry[WIDTH];
   assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

   // NOTE: non-blocking assignments for all registered state so every flop samples
   // pre-edge values; reset is checked first so it wins over a concurrent in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Self-checking bench for full_adder_reg at WIDTH=1 and WIDTH=8.

module tb_full_adder_reg;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       in_valid1, a1, b1, cin1;
   logic       sum1, cout1, ovf1, out_valid1;

   logic       in_valid8, cin8;
   logic [7:0] a8, b8, sum8;
   logic       cout8, ovf8, out_valid8;

   full_adder_reg #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .sum       (sum1),
      .cout      (cout1),
      .ovf       (ovf1),
      .out_valid (out_valid1)
   );

   full_adder_reg #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
      .sum       (sum8),
      .cout      (cout8),
      .ovf       (ovf8),
      .out_valid (out_valid8)
   );

   typedef struct {
      logic a, b, cin;
      logic sum, cout, ovf;
   } vec1_t;

   typedef struct {
      logic [7:0] a, b;
      logic       cin;
      logic [7:0] sum;
      logic       cout, ovf;
   } vec8_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] s, input logic c,
                         input logic o, input logic v);
      check({name, ".sum"},       64'(sum8),       64'(s));
      check({name, ".cout"},      64'(cout8),      64'(c));
      check({name, ".ovf"},       64'(ovf8),       64'(o));
      check({name, ".out_valid"}, 64'(out_valid8), 64'(v));
   endtask

   vec1_t tbl1 [8];
   vec8_t tbl8 [7];

   initial begin
      // Exhaustive WIDTH=1 table: {a,b,cin} -> {sum,cout,ovf}, ovf = cout ^ cin
      tbl1[0] = '{0,0,0, 0,0,0};
      tbl1[1] = '{0,0,1, 1,0,1};
      tbl1[2] = '{0,1,0, 1,0,0};
      tbl1[3] = '{0,1,1, 0,1,0};
      tbl1[4] = '{1,0,0, 1,0,0};
      tbl1[5] = '{1,0,1, 0,1,0};
      tbl1[6] = '{1,1,0, 0,1,1};
      tbl1[7] = '{1,1,1, 1,1,0};

      tbl8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl8[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl8[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl8[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};

      rst = 1'b1;
      in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      in_valid8 = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0;
      step();
      step();
      check("rst1.sum",       64'(sum1),       64'd0);
      check("rst1.cout",      64'(cout1),      64'd0);
      check("rst1.ovf",       64'(ovf1),       64'd0);
      check("rst1.out_valid", 64'(out_valid1), 64'd0);
      check8("rst8", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Exhaustive 1-bit, back-to-back
      for (int i = 0; i < 8; i++) begin
         in_valid1 = 1'b1;
         a1 = tbl1[i].a; b1 = tbl1[i].b; cin1 = tbl1[i].cin;
         step();
         check($sformatf("w1[%0d].sum", i),       64'(sum1),       64'(tbl1[i].sum));
         check($sformatf("w1[%0d].cout", i),      64'(cout1),      64'(tbl1[i].cout));
         check($sformatf("w1[%0d].ovf", i),       64'(ovf1),       64'(tbl1[i].ovf));
         check($sformatf("w1[%0d].out_valid", i), 64'(out_valid1), 64'd1);
      end

      // Reset wins over a concurrent valid operation
      in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      rst = 1'b1;
      step();
      check("rstpri.sum",       64'(sum1),       64'd0);
      check("rstpri.cout",      64'(cout1),      64'd0);
      check("rstpri.out_valid", 64'(out_valid1), 64'd0);
      rst = 1'b0;
      step();
      check("afterrst.sum",       64'(sum1),       64'd1);
      check("afterrst.cout",      64'(cout1),      64'd1);
      check("afterrst.out_valid", 64'(out_valid1), 64'd1);

      // Hold while in_valid=0 and operands toggle
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
      step();
      check("hold0.sum",       64'(sum1),       64'd1);
      check("hold0.cout",      64'(cout1),      64'd0);
      check("hold0.out_valid", 64'(out_valid1), 64'd1);
      in_valid1 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
         step();
         check($sformatf("hold%0d.sum", i),       64'(sum1),       64'd1);
         check($sformatf("hold%0d.cout", i),      64'(cout1),      64'd0);
         check($sformatf("hold%0d.ovf", i),       64'(ovf1),       64'd0);
         check($sformatf("hold%0d.out_valid", i), 64'(out_valid1), 64'd0);
      end

      // Directed 8-bit carry/overflow corners
      for (int i = 0; i < 7; i++) begin
         in_valid8 = 1'b1;
         a8 = tbl8[i].a; b8 = tbl8[i].b; cin8 = tbl8[i].cin;
         step();
         check8($sformatf("w8[%0d]", i), tbl8[i].sum, tbl8[i].cout, tbl8[i].ovf, 1'b1);
      end

      // Random back-to-back, reference is plain integer addition
      for (int i = 0; i < 1000; i++) begin
         logic [8:0] ref_full;
         logic       ref_ovf;
         in_valid8 = 1'b1;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         ref_full = 9'(a8) + 9'(b8) + 9'(cin8);
         ref_ovf  = (a8[7] == b8[7]) && (ref_full[7] != a8[7]);
         step();
         check8($sformatf("rnd[%0d]", i), ref_full[7:0], ref_full[8], ref_ovf, 1'b1);
      end

      // Reset mid-stream drops the in-flight vector
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
      step();
      check8("mid.pre", 8'h47, 1'b0, 1'b0, 1'b1);
      a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0;
      rst = 1'b1;
      step();
      check8("mid.rst", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      a8 = 8'hC0; b8 = 8'h50; cin8 = 1'b1;
      step();
      check8("mid.post", 8'h11, 1'b1, 1'b0, 1'b1);
      in_valid8 = 1'b0;
      step();
      check8("mid.idle", 8'h11, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
